pad_input_conditioner: RTL and testbench
========================================

Name: pad_input_conditioner

Overview:
- Sits directly downstream of the FPGA pad wrappers (IOBUF with PULLUP/PULLDOWN). It consumes each pad's O output.
- Per pad, it synchronises the asynchronous pad level into clk_i and applies a programmable consecutive-sample debounce filter.
- Outputs: the clean level plus single-cycle rise/fall event pulses, for the GPIO block and the wake/interrupt logic.
- Reset values are per pad, so pull-up pads do not generate spurious edges after reset.

Parameters:
- NUM_PADS, 32, number of pad inputs conditioned.
- SYNC_STAGES, 2, flip-flops in each synchroniser chain (legal range 2..4).
- DEBOUNCE_W, 8, width of the debounce threshold and the per-pad counters.
- RESET_VAL, '0 (NUM_PADS bits), reset level per pad. Set to 1 for pull-up pads, 0 for pull-down pads.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous, active-high.
- pad_in_i  in  NUM_PADS  raw O outputs of the pad cells (asynchronous).
- filter_en_i  in  NUM_PADS  per-pad debounce enable.
- debounce_thr_i  in  DEBOUNCE_W  shared threshold (quasi-static).
- pad_val_o  out  NUM_PADS  conditioned level.
- rise_o  out  NUM_PADS  one-cycle pulse on a 0->1 change of pad_val_o.
- fall_o  out  NUM_PADS  one-cycle pulse on a 1->0 change of pad_val_o.
- event_o  out  1  OR-reduction of rise_o | fall_o, registered with them.

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - Every synchroniser stage and pad_val_o take RESET_VAL.
  - Counters go to 0.
  - rise_o, fall_o and event_o go to 0.
  - Reset wins over all other activity, including mid-count.
- Synchroniser: plain shift chain, no logic between stages. s = last stage.
- Per-pad filter, with c the consecutive-mismatch counter and v = pad_val_o:
  - filter_en=0: v<=s and c<=0 every cycle.
  - filter_en=1, s!=v, c>=thr: v<=s, c<=0.
  - filter_en=1, s!=v, c<thr: c<=c+1.
  - filter_en=1, s==v: c<=0. A glitch shorter than thr+1 samples is fully discarded.
- The c>=thr compare makes a threshold lowered mid-count take effect on the next cycle. c never exceeds 2^DEBOUNCE_W-1.
- Latency from a pad_in_i change (held stable) to pad_val_o: SYNC_STAGES+1 cycles when filtering is off or thr=0; SYNC_STAGES+thr+1 cycles otherwise.
- rise_o/fall_o assert in the same cycle that pad_val_o first shows the new value, for exactly one cycle.
- event_o is registered from the same next-state terms as rise_o/fall_o, so it is coincident with them.
- Toggling filter_en_i mid-count: when disabled, the counter clears and v follows s. No edge is lost; at most one edge is reported per v change.
- Pads are fully independent; simultaneous events on several pads all pulse in the same cycle.

Optional Feature:
- Macro: PAD_COND_STICKY_EN.
- When defined, two extra ports are added:
  - irq_status_o, out, NUM_PADS: sticky, set by rise_o|fall_o, reset 0.
  - irq_clear_i, in, NUM_PADS: clears the corresponding irq_status_o bit.
- A set coinciding with a clear leaves the bit 1 (set wins).
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Package pad_cond_pkg holds:
  - SYNC_STAGES_MIN=2 and SYNC_STAGES_MAX=4, checked with an elaboration-time assertion.
  - typedef pad_edge_t, a struct of {rise, fall}.
- One sub-module, pad_debounce: a single pad's synchroniser, counter and edge logic, with a scalar RESET_VAL.
- The top level generates NUM_PADS instances and builds the event_o reduction plus the optional sticky register.

Test Plan:
- Reset release with RESET_VAL=32'h0000_00FF and pad_in_i=32'h0000_00FF held -> pad_val_o=32'h0000_00FF from the first cycle; no rise_o/fall_o ever pulses.
- Filter off, pad 3: 0->1 step -> pad_val_o[3]=1 and rise_o[3]=1 exactly SYNC_STAGES+1=3 cycles later; one-cycle pulse; event_o coincident.
- Filter on, thr=4, pad 5: high pulse of 4 cycles -> no change, no pulse. Same pad, high held 5+ cycles -> pad_val_o[5] rises SYNC_STAGES+5=7 cycles after the step.
- thr=200 mid-count at c=50, then lowered to 10 -> pad_val_o updates on the next cycle; exactly one rise_o pulse.
- Simultaneous 1->0 on pads 0 and 31, filter off -> fall_o=32'h8000_0001 for one cycle; rst_i asserted during a thr=100 count -> counter cleared, pad_val_o=RESET_VAL, no pulse.
- With PAD_COND_STICKY_EN, rise on pad 2 and irq_clear_i[2]=1 in the same cycle -> irq_status_o[2]=1; a clear the next cycle -> 0.

Source files
------------

// File: rtl/pad_cond_pkg.sv
// Shared definitions for the pad input conditioner: synchroniser depth limits
// and the per-pad edge event record.
package pad_cond_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    typedef struct packed {
        logic rise;
        logic fall;
    } pad_edge_t;

endpackage

// File: rtl/pad_debounce.sv
// One pad: synchroniser chain, consecutive-mismatch debounce counter and
// registered rise/fall detection. Next-state edges are exported for event_o.
module pad_debounce
    import pad_cond_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   DEBOUNCE_W  = 8,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pad_i,
    input  logic                  filter_en_i,
    input  logic [DEBOUNCE_W-1:0] thr_i,
    output logic                  val_o,
    output pad_edge_t             edge_o,
    output pad_edge_t             edge_next_o
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_val;
    logic [DEBOUNCE_W-1:0]  r_cnt;
    pad_edge_t              r_edge;

    logic                   w_s;
    logic                   w_val_next;
    logic [DEBOUNCE_W-1:0]  w_cnt_next;
    pad_edge_t              w_edge_next;

    assign w_s = r_sync[SYNC_STAGES-1];

    // The counter only grows while below thr, so it cannot wrap.
    always_comb begin
        w_val_next = r_val;
        w_cnt_next = '0;
        if (!filter_en_i) begin
            w_val_next = w_s;
        end else if (w_s != r_val) begin
            if (r_cnt >= thr_i) begin
                w_val_next = w_s;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
        w_edge_next.rise = w_val_next & ~r_val;
        w_edge_next.fall = ~w_val_next & r_val;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_val  <= RESET_VAL;
            r_cnt  <= '0;
            r_edge <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pad_i};
            r_val  <= w_val_next;
            r_cnt  <= w_cnt_next;
            r_edge <= w_edge_next;
        end
    end

    assign val_o       = r_val;
    assign edge_o      = r_edge;
    assign edge_next_o = w_edge_next;

endmodule

// File: rtl/pad_input_conditioner.sv
// Per-pad synchronise + debounce with rise/fall/event outputs.
// Define PAD_COND_STICKY_EN to add the sticky irq_status_o / irq_clear_i pair.
module pad_input_conditioner
    import pad_cond_pkg::*;
#(
    parameter int                  NUM_PADS    = 32,
    parameter int                  SYNC_STAGES = 2,
    parameter int                  DEBOUNCE_W  = 8,
    parameter logic [NUM_PADS-1:0] RESET_VAL   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_PADS-1:0]   pad_in_i,
    input  logic [NUM_PADS-1:0]   filter_en_i,
    input  logic [DEBOUNCE_W-1:0] debounce_thr_i,
    output logic [NUM_PADS-1:0]   pad_val_o,
    output logic [NUM_PADS-1:0]   rise_o,
    output logic [NUM_PADS-1:0]   fall_o,
    output logic                  event_o
`ifdef PAD_COND_STICKY_EN
    ,
    input  logic [NUM_PADS-1:0]   irq_clear_i,
    output logic [NUM_PADS-1:0]   irq_status_o
`endif
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_sync_check
        $error("pad_input_conditioner: SYNC_STAGES out of range");
    end

    pad_edge_t             w_edge      [NUM_PADS];
    pad_edge_t             w_edge_next [NUM_PADS];
    logic [NUM_PADS-1:0]   w_any_next;
    logic                  r_event;

    for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
        pad_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_W  (DEBOUNCE_W),
            .RESET_VAL   (RESET_VAL[gi])
        ) u_pad (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .pad_i       (pad_in_i[gi]),
            .filter_en_i (filter_en_i[gi]),
            .thr_i       (debounce_thr_i),
            .val_o       (pad_val_o[gi]),
            .edge_o      (w_edge[gi]),
            .edge_next_o (w_edge_next[gi])
        );
        assign rise_o[gi]     = w_edge[gi].rise;
        assign fall_o[gi]     = w_edge[gi].fall;
        assign w_any_next[gi] = w_edge_next[gi].rise | w_edge_next[gi].fall;
    end

    // Registered from the next-state edge terms so it lines up with rise_o/fall_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_event <= 1'b0;
        end else begin
            r_event <= |w_any_next;
        end
    end

    assign event_o = r_event;

`ifdef PAD_COND_STICKY_EN
    logic [NUM_PADS-1:0] r_irq_status;

    // Set has priority over a coincident clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_irq_status <= '0;
        end else begin
            r_irq_status <= (r_irq_status & ~irq_clear_i) | rise_o | fall_o;
        end
    end

    assign irq_status_o = r_irq_status;
`endif

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Scoreboard bench: a behavioural model predicts each cycle's outputs into a
// queue; a monitor on the falling edge pops and compares.
module tb_pad_input_conditioner;

    localparam int          N  = 32;
    localparam int          S  = 2;
    localparam int          W  = 8;
    localparam logic [31:0] RV = 32'h0000_00FF;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [N-1:0] pad_in_i;
    logic [N-1:0] filter_en_i;
    logic [W-1:0] debounce_thr_i;
    logic [N-1:0] pad_val_o;
    logic [N-1:0] rise_o;
    logic [N-1:0] fall_o;
    logic         event_o;
    logic [N-1:0] irq_clear_i;
`ifdef PAD_COND_STICKY_EN
    logic [N-1:0] irq_status_o;
`endif

    always #5 clk = ~clk;

    pad_input_conditioner #(
        .NUM_PADS    (N),
        .SYNC_STAGES (S),
        .DEBOUNCE_W  (W),
        .RESET_VAL   (RV)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .pad_in_i       (pad_in_i),
        .filter_en_i    (filter_en_i),
        .debounce_thr_i (debounce_thr_i),
        .pad_val_o      (pad_val_o),
        .rise_o         (rise_o),
        .fall_o         (fall_o),
        .event_o        (event_o)
`ifdef PAD_COND_STICKY_EN
        ,
        .irq_clear_i    (irq_clear_i),
        .irq_status_o   (irq_status_o)
`endif
    );

    typedef struct {
        logic [31:0] val;
        logic [31:0] rise;
        logic [31:0] fall;
        logic        evt;
        logic [31:0] irq;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model: input history delay line, accepted level, run lengths.
    logic [31:0] hist[$];
    logic [31:0] m_val, m_rise, m_fall, m_irq;
    int          m_run[N];

    // Current drive values used by the directed and random sequences.
    logic [31:0] d_pad, d_en, d_clr;
    int          d_thr;
    logic        d_rst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v, input int c);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp_v);
        end
    endtask

    task automatic model_edge();
        logic [31:0] s, nv, irq_n;
        exp_t e;
        if (d_rst) begin
            hist.delete();
            for (int k = 0; k < S; k++) hist.push_back(RV);
            m_val = RV; m_rise = '0; m_fall = '0; m_irq = '0;
            for (int p = 0; p < N; p++) m_run[p] = 0;
        end else begin
            s = hist[S-1];                       // value sampled S edges ago
            hist.push_front(d_pad);
            void'(hist.pop_back());
            irq_n = (m_irq & ~d_clr) | m_rise | m_fall;
            nv = m_val;
            for (int p = 0; p < N; p++) begin
                // A new level is accepted after more than thr consecutive disagreeing samples.
                if (s[p] == m_val[p]) m_run[p] = 0;
                else if (!d_en[p] || m_run[p] >= d_thr) begin nv[p] = s[p]; m_run[p] = 0; end
                else m_run[p] = m_run[p] + 1;
            end
            m_rise = nv & ~m_val;
            m_fall = ~nv & m_val;
            m_val  = nv;
            m_irq  = irq_n;
        end
        e.val = m_val; e.rise = m_rise; e.fall = m_fall;
        e.evt = |(m_rise | m_fall); e.irq = m_irq; e.cyc = cyc;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            rst_i          = d_rst;
            pad_in_i       = d_pad;
            filter_en_i    = d_en;
            debounce_thr_i = W'(d_thr);
            irq_clear_i    = d_clr;
            cyc++;
            model_edge();
        end
    endtask

    // Monitor: each falling edge reflects the posedge predicted one entry earlier.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("pad_val", pad_val_o, e.val, e.cyc);
                chk("rise", rise_o, e.rise, e.cyc);
                chk("fall", fall_o, e.fall, e.cyc);
                chk("event", {31'b0, event_o}, {31'b0, e.evt}, e.cyc);
`ifdef PAD_COND_STICKY_EN
                chk("irq_status", irq_status_o, e.irq, e.cyc);
`endif
            end
        end
    end

    initial begin
        d_pad = RV; d_en = '0; d_clr = '0; d_thr = 0; d_rst = 1'b1;
        rst_i = 1'b1; pad_in_i = RV; filter_en_i = '0; debounce_thr_i = '0; irq_clear_i = '0;
        for (int p = 0; p < N; p++) m_run[p] = 0;

        // Reset with pull-up pads held high: no edges expected.
        tick(3);
        d_rst = 1'b0;
        tick(6);

        // Filter off, pad 3 rises.
        d_pad[3] = 1'b1;
        tick(6);

        // Filter on thr=4, pad 5: 4-cycle glitch discarded, then a held level passes.
        d_en[5] = 1'b1; d_thr = 4;
        d_pad[5] = 1'b1; tick(4);
        d_pad[5] = 1'b0; tick(8);
        d_pad[5] = 1'b1; tick(10);

        // thr=200 with a long count, then lowered to 10.
        d_en[6] = 1'b1; d_thr = 200;
        d_pad[6] = 1'b1; tick(52);
        d_thr = 10; tick(5);

        // Simultaneous falls on pads 0 and 31, filter off.
        d_pad[31] = 1'b1; tick(5);
        d_pad[0] = 1'b0; d_pad[31] = 1'b0; tick(5);

        // Reset in the middle of a thr=100 count on pad 7.
        d_en[7] = 1'b1; d_thr = 100;
        d_pad[7] = 1'b0; tick(30);
        d_rst = 1'b1; tick(1);
        d_rst = 1'b0; d_pad = RV; d_en = '0; d_thr = 0; tick(6);

        // Pad 2 rise with clear overlapping the sticky set, then clear alone.
        d_pad[2] = 1'b0; tick(4);
        d_pad[2] = 1'b1; tick(2);
        d_clr[2] = 1'b1; tick(3);
        d_clr[2] = 1'b0; tick(3);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            if (i % 200 == 0) begin
                d_en  = $urandom;
                d_thr = int'($urandom_range(0, 5));
            end
            for (int p = 0; p < N; p++)
                if ($urandom_range(0, 15) == 0) d_pad[p] = ~d_pad[p];
            d_clr = $urandom & $urandom;
            d_rst = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        d_rst = 1'b0;
        tick(2);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
